iic_master_module: RTL and testbench

Single-clock I2C master that generates START, 7-bit address plus R/W, one data byte, ACK handling and STOP on the SCL/SDA pair consumed by the I2C slave stages. Each transaction is one byte, read or write, launched by a one-cycle start request from the host logic. SDA is open-drain: the master only pulls it low or releases it. SCL is driven push-pull by the master.

---
 rtl/iic_master_module.sv | 188 ++++++++++++++++++
 tb/tb_iic_master_module.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iic_master_module.sv
// Single-byte I2C master: START, 7-bit address + R/W, one data byte with ACK handling, STOP.
// SCL is push-pull, SDA open-drain; each bit slot is four quarter periods of CLK_DIV clocks.
`timescale 1ns/1ps
module iic_master_module #(
  parameter int unsigned CLK_DIV = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] dev_adr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       SCL,
  inout  logic       SDA
);
  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_PRE  = DW'(CLK_DIV - 2);

  typedef enum logic [3:0] {
    IDLE, START, ADDR, ADDR_ACK, WDATA, WACK, RDATA, RNACK, STOP
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic [1:0]      qtr_q, qtr_d;
  logic [2:0]      bit_q, bit_d;
  logic            rw_q, rw_d;
  logic [6:0]      adr_q, adr_d;
  logic [7:0]      wdata_q, wdata_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            samp_q, samp_d;
  logic [7:0]      rdata_q, rdata_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            ack_err_q, ack_err_d;
  logic            scl_q, scl_d;
  logic            sda_low_q, sda_low_d;
  logic            sync1_q, sync2_q;
  logic            tick, slot_end;
  logic [7:0]      tx_byte;

  assign rdata   = rdata_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign ack_err = ack_err_q;
  assign SCL     = scl_q;
  assign SDA     = sda_low_q ? 1'b0 : 1'bz;

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    qtr_d     = qtr_q;
    bit_d     = bit_q;
    rw_d      = rw_q;
    adr_d     = adr_q;
    wdata_d   = wdata_q;
    shreg_d   = shreg_q;
    samp_d    = samp_q;
    rdata_d   = rdata_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ack_err_d = ack_err_q;
    tick      = 1'b0;
    slot_end  = 1'b0;

    if (state_q != IDLE) begin
      tick     = (div_q == DIV_LAST);
      div_d    = tick ? '0 : div_q + 1'b1;
      slot_end = tick && (qtr_q == 2'd3);
      if (tick) qtr_d = qtr_q + 2'd1;
      if (tick && (qtr_q == 2'd2)) samp_d = sync2_q;
    end

    case (state_q)
      IDLE: if (start) begin
        state_d   = START;
        rw_d      = rw;
        adr_d     = dev_adr;
        wdata_d   = wdata;
        ack_err_d = 1'b0;
        busy_d    = 1'b1;
      end
      START: if (slot_end) begin
        state_d = ADDR;
        bit_d   = 3'd7;
      end
      ADDR: if (slot_end) begin
        if (bit_q == 3'd0) state_d = ADDR_ACK;
        else               bit_d   = bit_q - 3'd1;
      end
      ADDR_ACK: if (slot_end) begin
        bit_d = 3'd7;
        if (samp_q) begin
          ack_err_d = 1'b1;
          state_d   = STOP;
        end else begin
          state_d = rw_q ? RDATA : WDATA;
        end
      end
      WDATA: if (slot_end) begin
        if (bit_q == 3'd0) state_d = WACK;
        else               bit_d   = bit_q - 3'd1;
      end
      WACK: if (slot_end) begin
        if (samp_q) ack_err_d = 1'b1;
        state_d = STOP;
      end
      RDATA: begin
        if (tick && (qtr_q == 2'd2)) shreg_d = {shreg_q[6:0], sync2_q};
        if (slot_end) begin
          if (bit_q == 3'd0) state_d = RNACK;
          else               bit_d   = bit_q - 3'd1;
        end
      end
      RNACK: if (slot_end) state_d = STOP;
      STOP: begin
        // done fires one clock before the state returns to IDLE, so a start in the done cycle is not seen
        if ((qtr_q == 2'd3) && (div_q == DIV_PRE)) begin
          done_d = 1'b1;
          busy_d = 1'b0;
          if (rw_q && !ack_err_q) rdata_d = shreg_q;
        end
        if (slot_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    tx_byte   = {adr_q, rw_q};
    scl_d     = qtr_d[1];
    sda_low_d = 1'b0;
    case (state_d)
      IDLE:  scl_d = 1'b1;
      START: begin
        scl_d     = 1'b1;
        sda_low_d = qtr_d[1];
      end
      ADDR:  sda_low_d = ~tx_byte[bit_d];
      WDATA: sda_low_d = ~wdata_q[bit_d];
      STOP:  sda_low_d = (qtr_d != 2'd3);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      div_q     <= '0;
      qtr_q     <= '0;
      bit_q     <= '0;
      rw_q      <= 1'b0;
      adr_q     <= '0;
      wdata_q   <= '0;
      shreg_q   <= '0;
      samp_q    <= 1'b1;
      rdata_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      scl_q     <= 1'b1;
      sda_low_q <= 1'b0;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      qtr_q     <= qtr_d;
      bit_q     <= bit_d;
      rw_q      <= rw_d;
      adr_q     <= adr_d;
      wdata_q   <= wdata_d;
      shreg_q   <= shreg_d;
      samp_q    <= samp_d;
      rdata_q   <= rdata_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ack_err_q <= ack_err_d;
      scl_q     <= scl_d;
      sda_low_q <= sda_low_d;
      sync1_q   <= SDA;
      sync2_q   <= sync1_q;
    end
  end
endmodule

// File: tb/tb_iic_master_module.sv
// Bench for iic_master_module: behavioural I2C slave on the bus, bus monitor, transaction-level model.
`timescale 1ns/1ps
module tb_iic_master_module;
  localparam int CD    = 6;
  localparam int FULL  = 80 * CD;
  localparam int NACKL = 44 * CD;
  localparam int LIMIT = 100 * 4 * CD;
  localparam logic [6:0] SLV_ADR = 7'h7F;

  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, rw_i = 1'b0;
  logic [6:0] adr_i = '0;
  logic [7:0] wd_i = '0;
  logic [7:0] rdata;
  logic       busy, done, ack_err, SCL;
  wire        sda_bus;
  logic       slv_pull = 1'b0;

  assign sda_bus = slv_pull ? 1'b0 : 1'bz;
  pullup (sda_bus);

  iic_master_module #(.CLK_DIV(CD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rw(rw_i), .dev_adr(adr_i), .wdata(wd_i),
    .rdata(rdata), .busy(busy), .done(done), .ack_err(ack_err), .SCL(SCL), .SDA(sda_bus)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  logic [7:0] exp_rd = 8'h00;

  // slave: address SLV_ADR, stores acked write bytes, returns slv_rd on reads
  logic [7:0] slv_reg = 8'h00, slv_rd = 8'h00;
  logic       slv_dack = 1'b1;
  int         s_ph = 0, s_nb = 0;
  logic [7:0] s_sh = '0;
  logic       s_rw = 1'b0, s_hit = 1'b0, s_pscl = 1'b1, s_psda = 1'b1;

  always @(posedge clk) begin
    if (s_pscl && SCL && s_psda && !sda_bus) begin
      s_ph = 1; s_nb = 0; slv_pull <= 1'b0;
    end else if (s_pscl && SCL && !s_psda && sda_bus) begin
      s_ph = 0; slv_pull <= 1'b0;
    end else if (!s_pscl && SCL) begin
      if (s_nb < 8) s_sh = {s_sh[6:0], sda_bus};
      s_nb++;
    end else if (s_pscl && !SCL) begin
      case (s_ph)
        1: if (s_nb == 8) begin
             s_hit = (s_sh[7:1] == SLV_ADR); s_rw = s_sh[0]; slv_pull <= s_hit;
           end else if (s_nb == 9) begin
             s_nb = 0; slv_pull <= 1'b0;
             if (!s_hit) s_ph = 0;
             else if (s_rw) begin s_ph = 3; slv_pull <= !slv_rd[7]; end
             else s_ph = 2;
           end
        2: if (s_nb == 8) begin
             if (slv_dack) slv_reg = s_sh;
             slv_pull <= slv_dack;
           end else if (s_nb == 9) begin
             slv_pull <= 1'b0; s_ph = 0;
           end
        3: slv_pull <= (s_nb < 8) ? !slv_rd[7 - s_nb] : 1'b0;
        default: ;
      endcase
    end
    s_pscl = SCL; s_psda = sda_bus;
  end

  // bus monitor: SDA at SCL rises, START/STOP conditions, SCL rise spacing, done pulses
  logic m_bits[$];
  logic exp_bits[$];
  int   cyc = 0, m_last = -1, m_perr = 0, m_starts = 0, m_stops = 0, m_dones = 0;
  logic m_pscl = 1'b1, m_psda = 1'b1;

  always @(posedge clk) begin
    cyc++;
    if (m_pscl && SCL && m_psda && !sda_bus) m_starts++;
    if (m_pscl && SCL && !m_psda && sda_bus) m_stops++;
    if (!m_pscl && SCL) begin
      m_bits.push_back(sda_bus);
      if (m_last >= 0 && (cyc - m_last) != 4 * CD) m_perr++;
      m_last = cyc;
    end
    if (done) m_dones++;
    m_pscl = SCL; m_psda = sda_bus;
  end

  // expected bus bits at SCL rises for one transaction
  task automatic model_bits(input logic r, input logic [6:0] a, input logic [7:0] d,
                            input logic hit, input logic dack);
    logic [7:0] ab;
    ab = {a, r};
    exp_bits.delete();
    for (int i = 7; i >= 0; i--) exp_bits.push_back(ab[i]);
    exp_bits.push_back(!hit);
    if (hit) begin
      for (int i = 7; i >= 0; i--) exp_bits.push_back(d[i]);
      exp_bits.push_back(r ? 1'b1 : !dack);
    end
    exp_bits.push_back(1'b0);
  endtask

  function automatic int bits_diff();
    int n;
    n = (m_bits.size() == exp_bits.size()) ? 0 : 1000;
    for (int i = 0; i < m_bits.size() && i < exp_bits.size(); i++)
      if (m_bits[i] !== exp_bits[i]) n++;
    return n;
  endfunction

  task automatic launch(input logic r, input logic [6:0] a, input logic [7:0] d);
    m_bits.delete(); m_starts = 0; m_stops = 0; m_perr = 0; m_last = -1; m_dones = 0;
    rw_i = r; adr_i = a; wd_i = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output bit to);
    lat = 0;
    while (done !== 1'b1 && lat < LIMIT) begin
      @(negedge clk);
      lat++;
    end
    to = (done !== 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (SCL !== 1'b1) begin failures++; $display("FAIL rst_scl got=%b exp=1", SCL); end
    checks++; if (sda_bus !== 1'b1) begin failures++; $display("FAIL rst_sda got=%b exp=1", sda_bus); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", done); end
    checks++; if (ack_err !== 1'b0) begin failures++; $display("FAIL rst_ack_err got=%b exp=0", ack_err); end
    checks++; if (rdata !== 8'h00) begin failures++; $display("FAIL rst_rdata got=%h exp=00", rdata); end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_write_ack();
    int lat; bit to;
    slv_dack = 1'b1;
    launch(1'b0, 7'h7F, 8'hA5);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL wr_busy got=%b exp=1", busy); end
    wait_done(lat, to);
    model_bits(1'b0, 7'h7F, 8'hA5, 1'b1, 1'b1);
    checks++; if (to || lat < FULL - 1 || lat > FULL + 1) begin failures++; $display("FAIL wr_latency got=%0d exp=%0d", lat, FULL); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wr_busy_done got=%b exp=0", busy); end
    checks++; if (ack_err !== 1'b0) begin failures++; $display("FAIL wr_ack_err got=%b exp=0", ack_err); end
    checks++; if (bits_diff() != 0) begin failures++; $display("FAIL wr_bits got=%0d bits/%0d diff exp=%0d bits", m_bits.size(), bits_diff(), exp_bits.size()); end
    checks++; if (slv_reg !== 8'hA5) begin failures++; $display("FAIL wr_slave_reg got=%h exp=a5", slv_reg); end
    checks++; if (m_starts != 1 || m_stops != 1) begin failures++; $display("FAIL wr_start_stop got=%0d/%0d exp=1/1", m_starts, m_stops); end
    checks++; if (m_perr != 0) begin failures++; $display("FAIL wr_scl_period got=%0d bad exp=0", m_perr); end
    repeat (3) @(negedge clk);
    checks++; if (SCL !== 1'b1 || sda_bus !== 1'b1) begin failures++; $display("FAIL wr_idle_bus got=%b%b exp=11", SCL, sda_bus); end
  endtask

  task automatic test_read();
    int lat; bit to;
    slv_rd = 8'h3C;
    launch(1'b1, 7'h7F, 8'h00);
    wait_done(lat, to);
    exp_rd = 8'h3C;
    model_bits(1'b1, 7'h7F, 8'h3C, 1'b1, 1'b1);
    checks++; if (to || lat < FULL - 1 || lat > FULL + 1) begin failures++; $display("FAIL rd_latency got=%0d exp=%0d", lat, FULL); end
    checks++; if (rdata !== exp_rd) begin failures++; $display("FAIL rd_rdata got=%h exp=%h", rdata, exp_rd); end
    checks++; if (ack_err !== 1'b0) begin failures++; $display("FAIL rd_ack_err got=%b exp=0", ack_err); end
    checks++; if (bits_diff() != 0) begin failures++; $display("FAIL rd_bits got=%0d bits/%0d diff exp=%0d bits", m_bits.size(), bits_diff(), exp_bits.size()); end
    checks++; if (m_stops != 1) begin failures++; $display("FAIL rd_stop got=%0d exp=1", m_stops); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_addr_nack();
    int lat; bit to;
    launch(1'b0, 7'h12, 8'h55);
    wait_done(lat, to);
    model_bits(1'b0, 7'h12, 8'h55, 1'b0, 1'b1);
    checks++; if (to || lat < NACKL - 1 || lat > NACKL + 1) begin failures++; $display("FAIL nack_latency got=%0d exp=%0d", lat, NACKL); end
    checks++; if (ack_err !== 1'b1) begin failures++; $display("FAIL nack_ack_err got=%b exp=1", ack_err); end
    checks++; if (rdata !== exp_rd) begin failures++; $display("FAIL nack_rdata got=%h exp=%h", rdata, exp_rd); end
    checks++; if (bits_diff() != 0) begin failures++; $display("FAIL nack_bits got=%0d bits/%0d diff exp=%0d bits", m_bits.size(), bits_diff(), exp_bits.size()); end
    checks++; if (m_stops != 1 || m_perr != 0) begin failures++; $display("FAIL nack_bus got=%0d stops/%0d bad exp=1/0", m_stops, m_perr); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_random();
    int lat, exp_lat; bit to;
    logic r, hit, exp_err;
    logic [6:0] a;
    logic [7:0] d, exp_reg;
    for (int n = 0; n < 10; n++) begin
      r        = 1'($urandom_range(0, 1));
      a        = ($urandom_range(0, 2) == 0) ? 7'($urandom_range(0, 126)) : SLV_ADR;
      d        = 8'($urandom);
      slv_rd   = 8'($urandom);
      slv_dack = ($urandom_range(0, 3) != 0);
      hit      = (a == SLV_ADR);
      exp_err  = !hit || (!r && !slv_dack);
      exp_lat  = hit ? FULL : NACKL;
      exp_reg  = (hit && !r && slv_dack) ? d : slv_reg;
      if (hit && r) exp_rd = slv_rd;
      model_bits(r, a, r ? slv_rd : d, hit, slv_dack);
      launch(r, a, d);
      wait_done(lat, to);
      checks++; if (to || lat < exp_lat - 1 || lat > exp_lat + 1) begin failures++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", n, lat, exp_lat); end
      checks++; if (ack_err !== exp_err) begin failures++; $display("FAIL rnd%0d_ack_err got=%b exp=%b", n, ack_err, exp_err); end
      checks++; if (rdata !== exp_rd) begin failures++; $display("FAIL rnd%0d_rdata got=%h exp=%h", n, rdata, exp_rd); end
      checks++; if (bits_diff() != 0) begin failures++; $display("FAIL rnd%0d_bits got=%0d bits/%0d diff exp=%0d bits", n, m_bits.size(), bits_diff(), exp_bits.size()); end
      checks++; if (slv_reg !== exp_reg) begin failures++; $display("FAIL rnd%0d_slave_reg got=%h exp=%h", n, slv_reg, exp_reg); end
      checks++; if (m_starts != 1 || m_stops != 1 || m_perr != 0) begin failures++; $display("FAIL rnd%0d_bus got=%0d/%0d/%0d exp=1/1/0", n, m_starts, m_stops, m_perr); end
      repeat ($urandom_range(2, 6)) @(negedge clk);
    end
  endtask

  task automatic test_busy_rules();
    int lat; bit to;
    slv_dack = 1'b1;
    launch(1'b0, 7'h7F, 8'h11);
    repeat (150) @(negedge clk);
    rw_i = 1'b1; adr_i = 7'h12; wd_i = 8'h99; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL busy_mid got=%b exp=1", busy); end
    wait_done(lat, to);
    checks++; if (to || ack_err !== 1'b0) begin failures++; $display("FAIL busy_ack_err got=%b exp=0", ack_err); end
    checks++; if (slv_reg !== 8'h11) begin failures++; $display("FAIL busy_slave_reg got=%h exp=11", slv_reg); end
    checks++; if (rdata !== exp_rd) begin failures++; $display("FAIL busy_rdata got=%h exp=%h", rdata, exp_rd); end
    repeat (FULL) @(negedge clk);
    checks++; if (m_dones != 1) begin failures++; $display("FAIL busy_done_count got=%0d exp=1", m_dones); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL busy_after got=%b exp=0", busy); end
  endtask

  task automatic test_back_to_back();
    int lat; bit to;
    slv_dack = 1'b1;
    launch(1'b0, 7'h7F, 8'h5A);
    wait_done(lat, to);
    launch(1'b0, 7'h7F, 8'hC3);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_done_cycle_busy got=%b exp=0", busy); end
    repeat (4 * CD) @(negedge clk);
    checks++; if (busy !== 1'b0 || m_starts != 0) begin failures++; $display("FAIL b2b_ignored got=%b/%0d exp=0/0", busy, m_starts); end
    checks++; if (slv_reg !== 8'h5A) begin failures++; $display("FAIL b2b_first_reg got=%h exp=5a", slv_reg); end
    launch(1'b0, 7'h7F, 8'h6B);
    wait_done(lat, to);
    @(negedge clk);
    launch(1'b0, 7'h7F, 8'h77);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_next_cycle_busy got=%b exp=1", busy); end
    wait_done(lat, to);
    checks++; if (to || lat < FULL - 1 || lat > FULL + 1) begin failures++; $display("FAIL b2b_latency got=%0d exp=%0d", lat, FULL); end
    checks++; if (slv_reg !== 8'h77) begin failures++; $display("FAIL b2b_slave_reg got=%h exp=77", slv_reg); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int lat; bit to;
    slv_dack = 1'b1;
    launch(1'b0, 7'h50, 8'h3C);
    repeat (22 * CD) @(negedge clk);
    checks++; if (sda_bus !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL abort_pre got=%b%b exp=01", sda_bus, busy); end
    #2 rst_n = 1'b0;
    #1;
    exp_rd = 8'h00;
    checks++; if (SCL !== 1'b1) begin failures++; $display("FAIL abort_scl got=%b exp=1", SCL); end
    checks++; if (sda_bus !== 1'b1) begin failures++; $display("FAIL abort_sda got=%b exp=1", sda_bus); end
    checks++; if (busy !== 1'b0 || ack_err !== 1'b0) begin failures++; $display("FAIL abort_flags got=%b%b exp=00", busy, ack_err); end
    checks++; if (rdata !== exp_rd) begin failures++; $display("FAIL abort_rdata got=%h exp=%h", rdata, exp_rd); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    launch(1'b0, 7'h7F, 8'hE1);
    wait_done(lat, to);
    model_bits(1'b0, 7'h7F, 8'hE1, 1'b1, 1'b1);
    checks++; if (to || lat < FULL - 1 || lat > FULL + 1) begin failures++; $display("FAIL abort_new_latency got=%0d exp=%0d", lat, FULL); end
    checks++; if (ack_err !== 1'b0 || slv_reg !== 8'hE1) begin failures++; $display("FAIL abort_new_write got=%b/%h exp=0/e1", ack_err, slv_reg); end
    checks++; if (bits_diff() != 0) begin failures++; $display("FAIL abort_new_bits got=%0d bits/%0d diff exp=%0d bits", m_bits.size(), bits_diff(), exp_bits.size()); end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_ack();
    test_read();
    test_addr_nack();
    test_random();
    test_busy_rules();
    test_back_to_back();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
